// File: rtl/board_io_pkg.sv
// Shared types and default parameters for the board I/O conditioner.
package board_io_pkg;
  typedef enum logic [1:0] {ST_HOLD, ST_COUNT, ST_RUN} rst_state_t;

  localparam int N_BTN_DEF           = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 650000;
  localparam int RST_HOLD_CYCLES_DEF = 16;
  localparam int RST_BTN_IDX_DEF     = 0;
  localparam int SYNC_STAGES_DEF     = 2;

  // Counter width that stays legal (>= 1 bit) for a terminal count of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/board_io_conditioner_debounce_ch.sv
// One button channel: synchroniser, stability counter, press/release pulses.
module debounce_ch
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      press  <= 1'b0;
      rel    <= 1'b0;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (btn_s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= btn_s;
        cnt   <= '0;
        press <= btn_s;
        rel   <= !btn_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/board_io_conditioner.sv
// Board front end: debounced buttons plus system-reset sequencing from clock lock.
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF,
  parameter int RST_BTN_IDX     = RST_BTN_IDX_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             sys_rst,
  output logic             rst_done
);
  localparam int HW = cnt_w(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES - 1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   locked_s;
  logic                   abort;
  rst_state_t             state;
  logic [HW-1:0]          hold_cnt;

  assign locked_s = lock_sync[SYNC_STAGES-1];
  assign abort    = !locked_s || btn_level[RST_BTN_IDX];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_sync <= '0;
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      sys_rst   <= 1'b1;
      rst_done  <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
      if (abort) begin
        state    <= ST_HOLD;
        hold_cnt <= '0;
      end else begin
        case (state)
          ST_HOLD: begin
            state    <= ST_COUNT;
            hold_cnt <= '0;
          end
          ST_COUNT: begin
            if (hold_cnt == HOLD_MAX) begin
              state    <= ST_RUN;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_RUN:  state <= ST_RUN;
          default: state <= ST_HOLD;
        endcase
      end
      // Output stage lags the state by one edge, so release lands one cycle after ST_RUN entry.
      sys_rst  <= !(state == ST_RUN && !abort);
      rst_done <= sys_rst && state == ST_RUN && !abort;
    end
  end
endmodule
